weight_spad_loader: RTL

Streams filter weights from the global weight buffer into the PE-array weight scratchpads. It sits directly downstream of the weight GLB. On `start` it reads `NUM_PE_ROWS × KERNEL_SIZE` consecutive words from a base address and delivers each one on a valid/ready stream, tagged with its destination PE row. A 2-entry skid buffer absorbs the GLB's 1-cycle read latency, so backpressure never loses or duplicates a word.

---
 rtl/weight_spad_loader_pkg.sv | 27 ++
 rtl/weight_spad_loader_skid_fifo.sv | 53 +++++
 rtl/weight_spad_loader.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/weight_spad_loader_pkg.sv
// Shared types for the weight scratchpad loader: FSM states and skid-buffer entry.
package weight_spad_loader_pkg;

  localparam int unsigned WL_DATA_BITWIDTH = 16;
  localparam int unsigned WL_NUM_PE_ROWS   = 3;

  function automatic int unsigned min1_clog2(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  localparam int unsigned WL_ROW_BITWIDTH = min1_clog2(WL_NUM_PE_ROWS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } loader_state_e;

  // Row tag and last flag ride with the word so they stay aligned under backpressure.
  typedef struct packed {
    logic [WL_DATA_BITWIDTH-1:0] data;
    logic [WL_ROW_BITWIDTH-1:0]  pe_row;
    logic                        last;
  } spad_entry_t;

endpackage

// File: rtl/weight_spad_loader_skid_fifo.sv
// Two-entry skid FIFO that absorbs the GLB's one-cycle read latency.
module weight_skid_fifo
  import weight_spad_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  spad_entry_t push_entry,
  input  logic        pop,
  output spad_entry_t head,
  output logic [1:0]  count,
  output logic        empty,
  output logic        full
);

  spad_entry_t [1:0] mem_q, mem_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
    end
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'd2);

endmodule

// File: rtl/weight_spad_loader.sv
// Streams NUM_PE_ROWS*KERNEL_SIZE weights from the weight GLB to the PE scratchpads.
// Optional stall counter output enabled by defining WEIGHT_LOADER_PERF_CNT_EN.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | issuing GLB reads while credit allows
// DRAIN | all reads issued, emptying skid buffer and in-flight read
// DONE  | one-cycle completion pulse; a new start may be taken here
module weight_spad_loader
  import weight_spad_loader_pkg::*;
#(
  parameter int unsigned DATA_BITWIDTH = WL_DATA_BITWIDTH,
  parameter int unsigned ADDR_BITWIDTH = 10,
  parameter int unsigned KERNEL_SIZE   = 3,
  parameter int unsigned NUM_PE_ROWS   = WL_NUM_PE_ROWS
) (
  input  logic                             clk,
  input  logic                             reset,
`ifdef WEIGHT_LOADER_PERF_CNT_EN
  output logic [31:0]                      stall_cycles,
`endif
  input  logic                             start,
  input  logic [ADDR_BITWIDTH-1:0]         base_addr,
  output logic                             busy,
  output logic                             done,
  output logic                             glb_read_req,
  output logic [ADDR_BITWIDTH-1:0]         glb_r_addr,
  input  logic [DATA_BITWIDTH-1:0]         glb_r_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_BITWIDTH-1:0]         out_data,
  output logic [min1_clog2(NUM_PE_ROWS)-1:0] out_pe_row,
  output logic                             out_last
);

  localparam int unsigned TOTAL    = NUM_PE_ROWS * KERNEL_SIZE;
  localparam int unsigned REMAIN_W = $clog2(TOTAL + 1);
  localparam int unsigned ROW_W    = min1_clog2(NUM_PE_ROWS);
  localparam int unsigned COL_W    = min1_clog2(KERNEL_SIZE);

  loader_state_e          state_q, state_d;
  logic [ADDR_BITWIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [REMAIN_W-1:0]    remain_q, remain_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic                   inflight_q, inflight_d;
  logic [ROW_W-1:0]       tag_row_q, tag_row_d;
  logic                   tag_last_q, tag_last_d;

  logic                   pop, credit_ok, start_load, col_wrap;
  logic [2:0]             pending;
  spad_entry_t            push_entry, head;
  logic [1:0]             fifo_count;
  logic                   fifo_empty, fifo_full;

  assign push_entry = '{data: glb_r_data, pe_row: tag_row_q, last: tag_last_q};

  weight_skid_fifo u_skid (
    .clk        (clk),
    .reset      (reset),
    .push       (inflight_q),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (fifo_count),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  assign out_valid  = !fifo_empty;
  assign out_data   = head.data;
  assign out_pe_row = head.pe_row;
  assign out_last   = !fifo_empty && head.last;
  assign pop        = out_valid && out_ready;

  // A slot popped this cycle is reusable by a read issued this cycle.
  assign pending    = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign credit_ok  = (pending < (3'd2 + {2'b00, pop})) && (!fifo_full || pop);
  assign col_wrap   = (col_q == COL_W'(KERNEL_SIZE - 1));

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    remain_d     = remain_q;
    row_d        = row_q;
    col_d        = col_q;
    inflight_d   = 1'b0;
    tag_row_d    = tag_row_q;
    tag_last_d   = tag_last_q;
    glb_read_req = 1'b0;
    glb_r_addr   = '0;
    busy         = 1'b0;
    done         = 1'b0;
    start_load   = 1'b0;

    case (state_q)
      IDLE: begin
        start_load = start;
      end
      LOAD: begin
        busy = 1'b1;
        if (credit_ok) begin
          glb_read_req = 1'b1;
          glb_r_addr   = rd_addr_q;
          inflight_d   = 1'b1;
          tag_row_d    = row_q;
          tag_last_d   = col_wrap;
          rd_addr_d    = rd_addr_q + ADDR_BITWIDTH'(1);
          remain_d     = remain_q - REMAIN_W'(1);
          col_d        = col_wrap ? '0 : col_q + COL_W'(1);
          row_d        = col_wrap ? row_q + ROW_W'(1) : row_q;
          if (remain_q == REMAIN_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if ((fifo_count == {1'b0, pop}) && !inflight_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_d    = IDLE;
        start_load = start;
      end
      default: state_d = IDLE;
    endcase

    if (start_load) begin
      state_d   = LOAD;
      rd_addr_d = base_addr;
      remain_d  = REMAIN_W'(TOTAL);
      row_d     = '0;
      col_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      remain_q   <= '0;
      row_q      <= '0;
      col_q      <= '0;
      inflight_q <= 1'b0;
      tag_row_q  <= '0;
      tag_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      remain_q   <= remain_d;
      row_q      <= row_d;
      col_q      <= col_d;
      inflight_q <= inflight_d;
      tag_row_q  <= tag_row_d;
      tag_last_q <= tag_last_d;
    end
  end

`ifdef WEIGHT_LOADER_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_load) begin
      stall_cnt_d = '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule
